// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_arbiter
//  Description : Round-robin arbiter sharing one SDRAM access port between N
//                audio cores. One grant covers one access (command through
//                finished); a watchdog aborts accesses the controller never
//                answers and raises a sticky timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_arbiter #(
  parameter int N       = 3,     // requesters: 0 = record, 1 = play, 2 = spare
  parameter int TIMEOUT = 1024,  // BUSY cycles before an access is aborted (>= 2)
  parameter int TW      = 11     // watchdog width, 2**TW > TIMEOUT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N-1:0]      i_enable,
  input  logic              i_clear,
  input  logic [N-1:0]      req_read,
  input  logic [N-1:0]      req_write,
  input  logic [23*N-1:0]   req_addr,
  input  logic [32*N-1:0]   req_writedata,
  output logic [31:0]       req_readdata,
  output logic [N-1:0]      req_finished,
  output logic              sdram_read,
  output logic              sdram_write,
  output logic [22:0]       sdram_addr,
  output logic [31:0]       sdram_writedata,
  input  logic [31:0]       sdram_readdata,
  input  logic              sdram_finished,
  output logic [N-1:0]      o_grant,
  output logic              o_timeout
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Registered state. last_q doubles as the granted index while BUSY.
  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] last_q,  last_d;
  logic [TW-1:0] cnt_q,   cnt_d;
  logic          timeout_q, timeout_d;

  logic [N-1:0]  w_req;
  logic          w_found;
  logic [IW-1:0] w_next;
  logic          w_busy;
  logic          w_expire;
  logic          w_done;
  logic [22:0]   w_addr_arr  [N];
  logic [31:0]   w_wdata_arr [N];

  // Round-robin search: first set bit of r strictly after 'last', wrapping.
  // Iterating downward lets the smallest offset overwrite larger ones.
  function automatic logic [IW:0] pick_next(input logic [N-1:0] r,
                                            input logic [IW-1:0] last);
    logic [IW:0] res;
    int          cand;
    res = '0;
    for (int i = N; i >= 1; i--) begin
      cand = (int'(last) + i) % N;
      if (r[cand]) res = {1'b1, IW'(cand)};
    end
    return res;
  endfunction

  // Unpack the flat address / write-data buses into per-requester slices.
  for (genvar k = 0; k < N; k++) begin : g_slice
    assign w_addr_arr[k]  = req_addr[23*k +: 23];
    assign w_wdata_arr[k] = req_writedata[32*k +: 32];
  end

  assign w_req             = (req_read | req_write) & i_enable;
  assign {w_found, w_next} = pick_next(w_req, last_q);
  assign w_busy            = (state_q == ST_BUSY);
  // Watchdog fires on the TIMEOUT-th BUSY cycle (counter starts at 0).
  assign w_expire          = w_busy & ~sdram_finished & (cnt_q == TW'(TIMEOUT - 1));
  assign w_done            = w_busy & (sdram_finished | w_expire);

  assign req_readdata = sdram_readdata;
  assign o_grant      = grant_q;
  assign o_timeout    = timeout_q;

  // Command mux toward the controller and completion routing to the owner.
  always_comb begin
    sdram_read      = 1'b0;
    sdram_write     = 1'b0;
    sdram_addr      = '0;
    sdram_writedata = '0;
    req_finished    = '0;
    if (w_busy) begin
      sdram_read           = req_read[last_q];
      // Read wins when both are raised; that combination is illegal anyway.
      sdram_write          = req_write[last_q] & ~req_read[last_q];
      sdram_addr           = w_addr_arr[last_q];
      sdram_writedata      = w_wdata_arr[last_q];
      // A watchdog abort also pulses finished so the core never hangs.
      req_finished[last_q] = w_done;
    end
  end

  // Next-state logic for the IDLE/BUSY arbiter and its watchdog.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (i_clear) timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_found) begin
          state_d = ST_BUSY;
          grant_d = N'(1) << w_next;
          last_d  = w_next;
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + TW'(1);
        // Returning to IDLE forces a one-cycle bubble so a request still
        // high during its finished cycle is not re-granted as stale.
        if (w_done) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
        // Setting the sticky flag overrides a simultaneous clear.
        if (w_expire) timeout_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; requester 0 holds first priority out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      last_q    <= IW'(N - 1);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_arbiter
//  Description : Self-checking bench for sdram_arbiter (N=3, TIMEOUT=8):
//                directed scenarios plus randomized traffic compared against
//                a transaction-level owner/pointer reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

  localparam int NR = 3;
  localparam int TO = 8;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     en;
  logic              clr;
  logic [NR-1:0]     req_read;
  logic [NR-1:0]     req_write;
  logic [23*NR-1:0]  req_addr;
  logic [32*NR-1:0]  req_writedata;
  logic [31:0]       req_readdata;
  logic [NR-1:0]     req_finished;
  logic              sdram_read;
  logic              sdram_write;
  logic [22:0]       sdram_addr;
  logic [31:0]       sdram_writedata;
  logic [31:0]       sdram_readdata;
  logic              sdram_finished;
  logic [NR-1:0]     o_grant;
  logic              o_timeout;

  logic [22:0] ta_addr [NR];
  logic [31:0] ta_data [NR];

  for (genvar k = 0; k < NR; k++) begin : g_pack
    assign req_addr[23*k +: 23]      = ta_addr[k];
    assign req_writedata[32*k +: 32] = ta_data[k];
  end

  sdram_arbiter #(.N(NR), .TIMEOUT(TO), .TW(4)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_enable       (en),
    .i_clear        (clr),
    .req_read       (req_read),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_writedata  (req_writedata),
    .req_readdata   (req_readdata),
    .req_finished   (req_finished),
    .sdram_read     (sdram_read),
    .sdram_write    (sdram_write),
    .sdram_addr     (sdram_addr),
    .sdram_writedata(sdram_writedata),
    .sdram_readdata (sdram_readdata),
    .sdram_finished (sdram_finished),
    .o_grant        (o_grant),
    .o_timeout      (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the port (-1 = nobody), who was served last,
  // how many cycles the current access has been outstanding, sticky abort.
  int          m_owner;
  int          m_ptr;
  int          m_n;
  logic        m_sticky;
  logic        m_stall;
  logic [2:0]  fin_seen;
  logic [2:0]  obs_grant;

  task automatic check_value(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_ptr    = NR - 1;
    m_n      = 0;
    m_sticky = 1'b0;
    m_stall  = 1'b0;
    fin_seen = '0;
  endtask

  // One clock cycle: inputs already driven at the falling edge. Compare all
  // outputs against the model, advance the model across the rising edge.
  task automatic tick();
    logic [2:0]  elig, e_grant, e_fin;
    logic        e_rd, e_wr, busy, expire, fin, n_sticky;
    logic [22:0] e_addr;
    logic [31:0] e_data;
    int          n_owner, n_ptr, n_n, c;
    #1;
    busy    = (m_owner >= 0);
    e_grant = '0;
    e_rd    = 1'b0;
    e_wr    = 1'b0;
    e_addr  = '0;
    e_data  = '0;
    if (busy) begin
      e_grant = 3'(1 << m_owner);
      e_rd    = req_read[m_owner];
      e_wr    = req_write[m_owner] & ~req_read[m_owner];
      e_addr  = ta_addr[m_owner];
      e_data  = ta_data[m_owner];
    end
    expire = busy && !sdram_finished && (m_n == TO);
    fin    = busy && (sdram_finished || expire);
    e_fin  = fin ? e_grant : 3'b000;
    check_value("grant",    o_grant,         e_grant);
    check_value("finished", req_finished,    e_fin);
    check_value("rd_cmd",   sdram_read,      e_rd);
    check_value("wr_cmd",   sdram_write,     e_wr);
    check_value("addr",     sdram_addr,      e_addr);
    check_value("wdata",    sdram_writedata, e_data);
    check_value("timeout",  o_timeout,       m_sticky);
    check_value("rdata",    req_readdata,    sdram_readdata);
    obs_grant = o_grant;
    fin_seen  = e_fin;
    n_owner   = m_owner;
    n_ptr     = m_ptr;
    n_n       = m_n;
    n_sticky  = m_sticky;
    elig      = '0;
    if (busy) begin
      if (fin) n_owner = -1;
      else     n_n     = m_n + 1;
      if (expire)     n_sticky = 1'b1;
      else if (clr)   n_sticky = 1'b0;
    end else begin
      if (clr) n_sticky = 1'b0;
      elig = (req_read | req_write) & en;
      for (int off = 1; off <= NR; off++) begin
        c = (m_ptr + off) % NR;
        if (n_owner < 0 && elig[c]) begin
          n_owner = c;
          n_ptr   = c;
          n_n     = 1;
          m_stall = ($urandom_range(0, 6) == 0);
        end
      end
    end
    @(posedge clk);
    m_owner  = n_owner;
    m_ptr    = n_ptr;
    m_n      = n_n;
    m_sticky = n_sticky;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req_read       = '0;
    req_write      = '0;
    en             = 3'b111;
    clr            = 1'b0;
    sdram_finished = 1'b0;
    sdram_readdata = '0;
    for (int k = 0; k < NR; k++) begin
      ta_addr[k] = '0;
      ta_data[k] = '0;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge out of reset.
  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    check_value("rst_grant",   o_grant,      3'b000);
    check_value("rst_timeout", o_timeout,    1'b0);
    check_value("rst_fin",     req_finished, 3'b000);
    check_value("rst_rd",      sdram_read,   1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [2:0] seq [$];
  int         seq_t [$];

  // Run continuous requests; controller answers on the 2nd BUSY cycle.
  task automatic run_rr(input int cycles);
    seq.delete();
    seq_t.delete();
    for (int i = 0; i < cycles; i++) begin
      sdram_finished = (m_owner >= 0) && (m_n == 2);
      tick();
      if (obs_grant != 3'b000 && !(seq.size() > 0 && seq_t[$] == i - 1)) begin
        seq.push_back(obs_grant);
        seq_t.push_back(i);
      end
    end
    sdram_finished = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    clear_inputs();
    model_reset();
    @(negedge clk);
    do_reset();

    // Single requester: play reads 0x000010, data returns on the 4th cycle.
    req_read[1] = 1'b1;
    ta_addr[1]  = 23'h000010;
    tick();
    #1;
    check_value("single_grant", o_grant,    3'b010);
    check_value("single_rd",    sdram_read, 1'b1);
    check_value("single_addr",  sdram_addr, 23'h000010);
    tick();
    tick();
    tick();
    sdram_finished = 1'b1;
    sdram_readdata = 32'hDEADBEEF;
    #1;
    check_value("single_fin",   req_finished, 3'b010);
    check_value("single_rdata", req_readdata, 32'hDEADBEEF);
    tick();
    sdram_finished = 1'b0;
    req_read[1]    = 1'b0;
    #1;
    check_value("single_release", o_grant, 3'b000);
    tick();

    // Round robin over all three requesters.
    do_reset();
    req_read = 3'b111;
    run_rr(13);
    check_value("rr_count", seq.size(), 4);
    if (seq.size() >= 4) begin
      check_value("rr_g0", seq[0], 3'b001);
      check_value("rr_g1", seq[1], 3'b010);
      check_value("rr_g2", seq[2], 3'b100);
      check_value("rr_g3", seq[3], 3'b001);
      for (int i = 1; i < 4; i++)
        check_value("rr_spacing", seq_t[i] - seq_t[i-1], 3);
    end

    // Write muxing: record writes while play reads.
    do_reset();
    req_write[0] = 1'b1;
    ta_addr[0]   = 23'h400000;
    ta_data[0]   = 32'h12345678;
    req_read[1]  = 1'b1;
    ta_addr[1]   = 23'h000123;
    tick();
    #1;
    check_value("wr_grant", o_grant,         3'b001);
    check_value("wr_cmd_d", sdram_write,     1'b1);
    check_value("wr_addr",  sdram_addr,      23'h400000);
    check_value("wr_data",  sdram_writedata, 32'h12345678);
    sdram_finished = 1'b1;
    tick();
    sdram_finished = 1'b0;
    req_write[0]   = 1'b0;
    tick();
    #1;
    check_value("wr_next_grant", o_grant, 3'b010);
    sdram_finished = 1'b1;
    tick();
    sdram_finished = 1'b0;
    req_read[1]    = 1'b0;
    tick();

    // Enable masking: requester 1 requests but is disabled.
    do_reset();
    en       = 3'b101;
    req_read = 3'b111;
    run_rr(13);
    check_value("mask_count", seq.size(), 4);
    foreach (seq[i]) check_value("mask_no1", seq[i][1], 1'b0);
    if (seq.size() >= 4) begin
      check_value("mask_g0", seq[0], 3'b001);
      check_value("mask_g1", seq[1], 3'b100);
      check_value("mask_g2", seq[2], 3'b001);
      check_value("mask_g3", seq[3], 3'b100);
    end

    // Timeout: requester 2 granted, controller never answers.
    do_reset();
    req_read[2] = 1'b1;
    tick();
    for (int n = 1; n <= TO; n++) begin
      #1;
      check_value("to_fin", req_finished, (n == TO) ? 3'b100 : 3'b000);
      tick();
    end
    req_read[2] = 1'b0;
    #1;
    check_value("to_flag", o_timeout, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #1;
    check_value("to_clear", o_timeout, 1'b0);
    tick();

    // Reset mid-access, with the sticky flag previously set.
    req_read[2] = 1'b1;
    for (int n = 0; n <= TO; n++) tick();
    req_read[2] = 1'b0;
    req_read[0] = 1'b1;
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check_value("mid_rst_rd",    sdram_read, 1'b0);
    check_value("mid_rst_grant", o_grant,    3'b000);
    check_value("mid_rst_to",    o_timeout,  1'b0);
    @(negedge clk);
    model_reset();
    rst_n    = 1'b1;
    req_read = 3'b111;
    tick();
    #1;
    check_value("post_rst_grant", o_grant, 3'b001);
    tick();

    // Randomized traffic against the reference model.
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int k = 0; k < NR; k++) begin
        if (fin_seen[k] || ((req_read[k] | req_write[k]) && $urandom_range(0, 49) == 0)) begin
          req_read[k]  = 1'b0;
          req_write[k] = 1'b0;
        end else if (!(req_read[k] | req_write[k]) && $urandom_range(0, 9) < 3) begin
          if ($urandom_range(0, 1) == 1) req_read[k]  = 1'b1;
          else                           req_write[k] = 1'b1;
          ta_addr[k] = 23'($urandom);
          ta_data[k] = $urandom;
        end
      end
      if ($urandom_range(0, 19) == 0) en = 3'($urandom_range(0, 7));
      clr            = ($urandom_range(0, 19) == 0);
      sdram_readdata = $urandom;
      sdram_finished = (m_owner >= 0) && !m_stall && ($urandom_range(0, 9) < 4);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdram_arbiter.md
# sdram_arbiter

Round-robin arbiter that shares the single SDRAM access port (read/write/addr/data/finished handshake) between N audio cores: record, play and future loop/effect cores. Sits between the cores and the SDRAM controller wrapper. Each grant covers exactly one access, from command to `finished`, so the cores keep their existing hold-until-finished handshake unchanged. A watchdog releases the port if the controller never answers.

## Interface
Parameters:
- `N`, 3: number of requesters; index 0 = record, 1 = play, 2 = spare.
- `TIMEOUT`, 1024: cycles a granted access may wait for `finished` before it is aborted; must be at least 2.
- `TW`, 11: timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- `i_clk`  in  1  system clock; all logic on its rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_enable`  in  N  per-requester enable from the top controller; a disabled requester is never granted.
- `i_clear`  in  1  clears `o_timeout` (synchronous, level).
- `req_read`  in  N  read request per requester; held high until its `req_finished`.
- `req_write`  in  N  write request per requester; held high until its `req_finished`.
- `req_addr`  in  23*N  address; slice k is `[23k+22:23k]`.
- `req_writedata`  in  32*N  write data; slice k is `[32k+31:32k]`.
- `req_readdata`  out  32  SDRAM read data, broadcast to all requesters.
- `req_finished`  out  N  one-hot completion pulse to the granted requester only.
- `sdram_read`  out  1  read command to the controller.
- `sdram_write`  out  1  write command to the controller.
- `sdram_addr`  out  23  muxed address.
- `sdram_writedata`  out  32  muxed write data.
- `sdram_readdata`  in  32  controller read data.
- `sdram_finished`  in  1  controller completion pulse; also marks read data valid.
- `o_grant`  out  N  registered one-hot grant; all zeros when idle.
- `o_timeout`  out  1  sticky flag, set when an access is aborted.

## Operation
- State machine with two states: IDLE and BUSY.
- Request vector: `req[k] = (req_read[k] | req_write[k]) & i_enable[k]`.
- **IDLE:**
  - If `req` is nonzero, choose the first set bit searching upward from `last+1`, wrapping modulo N.
  - Register `o_grant` to that one-hot value, set `last` to that index, clear the watchdog counter, and go to BUSY.
  - If `req` is zero, stay in IDLE.
- **BUSY, granted index g:**
  - `sdram_read = req_read[g]`.
  - `sdram_write = req_write[g] & ~req_read[g]`. If both are high, read wins and the write is ignored; this combination is illegal.
  - `sdram_addr` and `sdram_writedata` come from slice g.
  - `req_finished[g] = sdram_finished`, combinational. All other `req_finished` bits are 0.
  - Watchdog counter increments every BUSY cycle.
- BUSY → IDLE on `sdram_finished`: `o_grant` clears the next cycle.
- BUSY → IDLE on timeout, when the counter reaches TIMEOUT−1 without `sdram_finished`:
  - Set `o_timeout`.
  - Pulse `req_finished[g]` for that cycle so the core does not hang; its read data is invalid.
- Enable changes: clearing `i_enable[g]` while g is granted does not abort the access.
- Withdrawn requests: if a requester drops its request mid-grant, the command outputs follow it low and the grant stays until finished or timeout.
- In IDLE, all `sdram_*` command outputs and all `req_finished` bits are 0.
- `req_readdata = sdram_readdata` always, unregistered.
- `o_timeout` set takes priority over `i_clear` in the same cycle.

## Timing
- Reset values: state IDLE, `o_grant` 0, `last` = N−1 (requester 0 has first priority), counter 0, `o_timeout` 0. All command outputs and `req_finished` are 0.
- Reset asserted mid-access drops the commands immediately (asynchronous). No `req_finished` is issued.
- Grant latency: request seen in IDLE at cycle t → `o_grant` and the SDRAM command are valid at t+1.
- `finished` at cycle t:
  - The requester sees `req_finished` at cycle t.
  - IDLE at t+1: a mandatory one-cycle bubble, so a requester that is still high during its finished cycle is not re-granted as a stale request.
  - Next grant at t+2.
- Back-to-back accesses from one requester therefore cost the access time plus 2 cycles each.
- Fairness: with all N requesting continuously, grants rotate 0,1,2,0,… No requester waits more than N−1 accesses.
- Timeout abort: fires at exactly TIMEOUT BUSY cycles after the grant cycle.

## Test plan
- **Single requester:** reset, then play (k=1) reads addr 0x000010; controller returns 0xDEADBEEF with `finished` 3 cycles after the command.
  - Required: `o_grant`=3'b010 one cycle after the request.
  - Required: `req_finished`=3'b010 for 1 cycle with `req_readdata`=0xDEADBEEF.
  - Required: `o_grant`=0 the next cycle.
- **Round robin:** all three requesters continuously request, with 1-cycle `finished`.
  - Required: grant sequence 001,010,100,001.
  - Required: each grant 3 cycles apart.
- **Write muxing:** record (k=0) writes 0x12345678 to 0x400000 while play reads.
  - Required: first grant goes to record, with `sdram_write`=1, `sdram_addr`=0x400000, `sdram_writedata`=0x12345678.
  - Required: play is granted after the bubble.
- **Enable masking:** `i_enable`=3'b101 with all requesting.
  - Required: requester 1 is never granted.
  - Required: grants alternate 001,100.
- **Timeout:** TIMEOUT=8; grant requester 2; controller never finishes.
  - Required: `req_finished`[2] pulses on the 8th BUSY cycle and `o_timeout` becomes 1.
  - Required: `i_clear` returns `o_timeout` to 0.
- **Reset mid-access:** assert `i_rst_n`=0 during BUSY.
  - Required: `sdram_read`, `o_grant` and `o_timeout` are 0 immediately.
  - Required: after release, requester 0 wins a simultaneous 0/1/2 request.
